// File: rtl/pipe_mem_bank_if.sv
// Port bundle for pipe_mem_bank: I-port read bus, D-port read/write bus and ready.
interface pipe_mem_bank_if #(
  parameter int DW = 32
);
  localparam int NB = DW / 8;

  logic          ready;
  logic          i_cen;
  logic [31:0]   i_addr;
  logic          i_hold;
  logic          i_flush;
  logic [DW-1:0] i_q;
  logic          d_cen;
  logic          d_wen;
  logic [NB-1:0] d_be;
  logic [31:0]   d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_hold;
  logic          d_flush;
  logic [DW-1:0] d_q;
  logic          d_err;

  modport master (
    output i_cen, i_addr, i_hold, i_flush,
    output d_cen, d_wen, d_be, d_addr, d_wdata, d_hold, d_flush,
    input  ready, i_q, d_q, d_err
  );

  modport slave (
    input  i_cen, i_addr, i_hold, i_flush,
    input  d_cen, d_wen, d_be, d_addr, d_wdata, d_hold, d_flush,
    output ready, i_q, d_q, d_err
  );
endinterface

// File: rtl/pipe_mem_bank.sv
// Two-port pipeline memory: registered I read port, registered D read/write port with
// byte enables, and a post-reset clear sequencer that zeroes the array before RUN.
module pipe_mem_bank #(
  parameter int DW           = 32,
  parameter int AW           = 8,
  parameter bit CLEAR_ON_RST = 1'b1,
  parameter bit FWD          = 1'b1
) (
  input  logic            clk,
  input  logic            nrst,
  pipe_mem_bank_if.slave  bus
);
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'b01,
    ST_RUN   = 2'b10
  } state_e;

  localparam state_e RST_STATE = CLEAR_ON_RST ? ST_CLEAR : ST_RUN;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] i_q_q, i_q_d;
  logic [DW-1:0] d_q_q, d_q_d;
  logic          err_q, err_d;

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] i_idx_s, d_idx_s;
  logic          mis_s, run_s, clr_s, wr_s;
  logic [DW-1:0] i_old_s, d_old_s, merge_s, i_rd_s;
  logic          unused_addr_s;

  assign i_idx_s = bus.i_addr[AW+1:2];
  assign d_idx_s = bus.d_addr[AW+1:2];
  assign run_s   = (state_q == ST_RUN);
  assign clr_s   = (state_q == ST_CLEAR);
  assign mis_s   = bus.d_cen && (bus.d_addr[1:0] != 2'b00);
  assign wr_s    = run_s && bus.d_cen && bus.d_wen && !mis_s;
  assign i_old_s = mem_q[i_idx_s];
  assign d_old_s = mem_q[d_idx_s];

  // Upper address bits alias and I-port low bits are ignored by design.
  assign unused_addr_s = ^{bus.i_addr[31:AW+2], bus.i_addr[1:0], bus.d_addr[31:AW+2]};

  // Word as it will look after this cycle's D write, used for I-port forwarding.
  always_comb begin
    merge_s = d_old_s;
    for (int k = 0; k < NB; k++) begin
      if (bus.d_be[k]) begin
        merge_s[8*k +: 8] = bus.d_wdata[8*k +: 8];
      end else begin
        merge_s[8*k +: 8] = d_old_s[8*k +: 8];
      end
    end
  end

  assign i_rd_s = (FWD && wr_s && (i_idx_s == d_idx_s)) ? merge_s : i_old_s;

  // Next-state and output-register logic for the CLEAR/RUN sequencer and both ports.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    i_q_d   = i_q_q;
    d_q_d   = d_q_q;
    err_d   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        i_q_d = '0;
        d_q_d = '0;
        if (cnt_q == {AW{1'b1}}) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_RUN: begin
        // Hold outranks flush, flush outranks a fresh read.
        if (bus.i_hold) begin
          i_q_d = i_q_q;
        end else if (bus.i_flush) begin
          i_q_d = '0;
        end else if (bus.i_cen) begin
          i_q_d = i_rd_s;
        end else begin
          i_q_d = i_q_q;
        end
        if (bus.d_hold) begin
          d_q_d = d_q_q;
        end else if (bus.d_flush) begin
          d_q_d = '0;
        end else if (bus.d_cen) begin
          d_q_d = d_old_s;
        end else begin
          d_q_d = d_q_q;
        end
        err_d = mis_s;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    ready_d = (state_d == ST_RUN);
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      i_q_q   <= '0;
      d_q_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      i_q_q   <= i_q_d;
      d_q_q   <= d_q_d;
      err_q   <= err_d;
    end
  end

  // Storage array: clear sweep or byte-lane write; nothing is written while in reset.
  always_ff @(posedge clk) begin
    if (nrst) begin
      if (clr_s) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_s) begin
        for (int k = 0; k < NB; k++) begin
          if (bus.d_be[k]) begin
            mem_q[d_idx_s][8*k +: 8] <= bus.d_wdata[8*k +: 8];
          end
        end
      end
    end
  end

  assign bus.ready = ready_q;
  assign bus.i_q   = i_q_q;
  assign bus.d_q   = d_q_q;
  assign bus.d_err = err_q;
endmodule

// File: tb/tb_pipe_mem_bank.sv
// Scoreboard bench for pipe_mem_bank: two instances (FWD=1 and FWD=0) share stimulus and
// are compared against a word-array reference model.
module tb_pipe_mem_bank;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic        icen, ihold, iflush, dcen, dwen, dhold, dflush;
    logic [3:0]  dbe;
    logic [31:0] iaddr, daddr, wdata;
  } stim_t;

  typedef struct {
    logic [31:0] iqf, iqn, dq;
    logic        err;
  } exp_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  pipe_mem_bank_if #(.DW(DW)) bus_f ();
  pipe_mem_bank_if #(.DW(DW)) bus_n ();

  pipe_mem_bank #(.DW(DW), .AW(AW), .CLEAR_ON_RST(1'b1), .FWD(1'b1)) dut_f (
    .clk(clk), .nrst(nrst), .bus(bus_f));
  pipe_mem_bank #(.DW(DW), .AW(AW), .CLEAR_ON_RST(1'b1), .FWD(1'b0)) dut_n (
    .clk(clk), .nrst(nrst), .bus(bus_n));

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_iqf, m_iqn, m_dq;
  logic        m_err;
  exp_t        sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    bus_f.i_cen = s.icen;  bus_f.i_addr = s.iaddr; bus_f.i_hold = s.ihold; bus_f.i_flush = s.iflush;
    bus_f.d_cen = s.dcen;  bus_f.d_wen = s.dwen;   bus_f.d_be = s.dbe;     bus_f.d_addr = s.daddr;
    bus_f.d_wdata = s.wdata; bus_f.d_hold = s.dhold; bus_f.d_flush = s.dflush;
    bus_n.i_cen = s.icen;  bus_n.i_addr = s.iaddr; bus_n.i_hold = s.ihold; bus_n.i_flush = s.iflush;
    bus_n.d_cen = s.dcen;  bus_n.d_wen = s.dwen;   bus_n.d_be = s.dbe;     bus_n.d_addr = s.daddr;
    bus_n.d_wdata = s.wdata; bus_n.d_hold = s.dhold; bus_n.d_flush = s.dflush;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.icen   = ($urandom_range(0, 3) != 0);
    s.ihold  = ($urandom_range(0, 7) == 0);
    s.iflush = ($urandom_range(0, 7) == 0);
    s.dcen   = ($urandom_range(0, 3) != 0);
    s.dwen   = ($urandom_range(0, 1) == 1);
    s.dhold  = ($urandom_range(0, 7) == 0);
    s.dflush = ($urandom_range(0, 7) == 0);
    s.dbe    = 4'($urandom_range(0, 15));
    s.daddr  = rand_addr();
    s.iaddr  = ($urandom_range(0, 3) == 0) ? s.daddr : rand_addr();
    s.wdata  = $urandom;
    return s;
  endfunction

  task automatic model_clear();
    for (int w = 0; w < DEPTH; w++) m_mem[w] = 32'h0;
    m_iqf = 32'h0; m_iqn = 32'h0; m_dq = 32'h0; m_err = 1'b0;
  endtask

  // One RUN cycle: apply stimulus, advance the model, queue expected outputs.
  task automatic cyc(input stim_t s);
    int          ii, di;
    logic        mis, wr;
    logic [31:0] neww;
    exp_t        e;
    @(negedge clk);
    drive(s);
    ii   = int'(s.iaddr[AW+1:2]);
    di   = int'(s.daddr[AW+1:2]);
    mis  = s.dcen && (s.daddr[1:0] != 2'b00);
    wr   = s.dcen && s.dwen && !mis;
    neww = m_mem[di];
    for (int k = 0; k < 4; k++) if (s.dbe[k]) neww[8*k +: 8] = s.wdata[8*k +: 8];
    if (!s.ihold) begin
      if (s.iflush) begin
        m_iqf = 32'h0; m_iqn = 32'h0;
      end else if (s.icen) begin
        m_iqf = (wr && ii == di) ? neww : m_mem[ii];
        m_iqn = m_mem[ii];
      end
    end
    if (!s.dhold) begin
      if (s.dflush) m_dq = 32'h0;
      else if (s.dcen) m_dq = m_mem[di];
    end
    if (wr) m_mem[di] = neww;
    m_err = mis;
    e.iqf = m_iqf; e.iqn = m_iqn; e.dq = m_dq; e.err = m_err;
    @(posedge clk);
    sb.push_back(e);
    #1;
    drive(stim_t'(0));
  endtask

  // Monitor: compare every pending expectation against both instances.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("iq_fwd1", bus_f.i_q, e.iqf);
      chk("iq_fwd0", bus_n.i_q, e.iqn);
      chk("dq_fwd1", bus_f.d_q, e.dq);
      chk("dq_fwd0", bus_n.d_q, e.dq);
      chk("err_fwd1", {31'd0, bus_f.d_err}, {31'd0, e.err});
      chk("err_fwd0", {31'd0, bus_n.d_err}, {31'd0, e.err});
      chk("ready_run", {31'd0, bus_f.ready & bus_n.ready}, 32'd1);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, bus_f.ready | bus_n.ready}, 32'd0);
    chk({tag, "_iq"}, bus_f.i_q | bus_n.i_q, 32'h0);
    chk({tag, "_dq"}, bus_f.d_q | bus_n.d_q, 32'h0);
    chk({tag, "_err"}, {31'd0, bus_f.d_err | bus_n.d_err}, 32'd0);
  endtask

  // Release reset with junk inputs and measure cycles until ready.
  task automatic release_and_clear(input string tag);
    int found;
    found = 0;
    @(negedge clk);
    nrst = 1'b1;
    drive(rand_stim());
    for (int c = 1; c <= 40 && found == 0; c++) begin
      @(posedge clk);
      #1;
      chk({tag, "_clr_iq"}, bus_f.i_q | bus_n.i_q, 32'h0);
      chk({tag, "_clr_dq"}, bus_f.d_q | bus_n.d_q, 32'h0);
      chk({tag, "_clr_err"}, {31'd0, bus_f.d_err | bus_n.d_err}, 32'd0);
      chk({tag, "_ready_eq"}, {31'd0, bus_n.ready}, {31'd0, bus_f.ready});
      if (bus_f.ready) found = c;
      drive(rand_stim());
    end
    drive(stim_t'(0));
    chk({tag, "_ready_latency"}, found, DEPTH);
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    drive(stim_t'(0));
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("por");

    // Abort the first clear sweep at counter 7.
    @(negedge clk);
    nrst = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk({"mid_clear_ready"}, {31'd0, bus_f.ready}, 32'd0);
    nrst = 1'b0;
    #1;
    chk_zero("rst_clear");
    repeat (2) @(posedge clk);
    release_and_clear("rst1");

    // Every word reads back zero after the sweep, via aliased addresses.
    for (int w = 0; w < DEPTH; w++) begin
      s = '0;
      s.icen = 1'b1; s.iaddr = {20'($urandom), 6'(w), 6'(w * 4)} ;
      s.iaddr = (s.iaddr & 32'hFFFF_FFC0) | (32'(w) << 2);
      s.dcen = 1'b1; s.daddr = (32'($urandom) & 32'hFFFF_FFC0) | (32'(w) << 2);
      cyc(s);
      chk("t1_iq_zero", bus_f.i_q, 32'h0);
    end

    // Full write then single-lane merge.
    s = '0; s.dcen = 1'b1; s.dwen = 1'b1; s.dbe = 4'hF; s.daddr = 32'h10; s.wdata = 32'hDEADBEEF;
    cyc(s);
    s.dbe = 4'b0010; s.wdata = 32'h00005500;
    cyc(s);
    s = '0; s.dcen = 1'b1; s.daddr = 32'h10;
    cyc(s);
    chk("t2_dq", bus_f.d_q, 32'hDEAD55EF);

    // Same-cycle I read of the word D is writing.
    s = '0; s.icen = 1'b1; s.iaddr = 32'h20;
    s.dcen = 1'b1; s.dwen = 1'b1; s.dbe = 4'hF; s.daddr = 32'h20; s.wdata = 32'h12345678;
    cyc(s);
    chk("t3_iq_fwd1", bus_f.i_q, 32'h12345678);
    chk("t3_iq_fwd0", bus_n.i_q, 32'h0);
    chk("t3_dq", bus_f.d_q | bus_n.d_q, 32'h0);

    // Hold beats flush beats read.
    s = '0; s.dcen = 1'b1; s.dwen = 1'b1; s.dbe = 4'hF; s.daddr = 32'h04; s.wdata = 32'hA5A5A5A5;
    cyc(s);
    s.daddr = 32'h08; s.wdata = 32'h11111111;
    cyc(s);
    s = '0; s.icen = 1'b1; s.iaddr = 32'h08;
    cyc(s);
    s.iaddr = 32'h04; s.ihold = 1'b1; s.iflush = 1'b1;
    cyc(s);
    chk("t4_hold", bus_f.i_q, 32'h11111111);
    s.ihold = 1'b0;
    cyc(s);
    chk("t4_flush", bus_f.i_q, 32'h0);
    s.iflush = 1'b0;
    cyc(s);
    chk("t4_read", bus_f.i_q, 32'hA5A5A5A5);

    // Misaligned write: one-cycle error, no store.
    s = '0; s.dcen = 1'b1; s.dwen = 1'b1; s.dbe = 4'hF; s.daddr = 32'h22; s.wdata = 32'hFFFFFFFF;
    cyc(s);
    chk("t5_err", {31'd0, bus_f.d_err}, 32'd1);
    chk("t5_trunc_read", bus_f.d_q, 32'h12345678);
    cyc(stim_t'(0));
    chk("t5_err_clear", {31'd0, bus_f.d_err}, 32'd0);
    s = '0; s.dcen = 1'b1; s.daddr = 32'h20;
    cyc(s);
    chk("t5_word", bus_f.d_q, 32'h12345678);

    for (int n = 0; n < 500; n++) cyc(rand_stim());

    // Reset asserted in RUN in the middle of a write.
    s = '0; s.dcen = 1'b1; s.dwen = 1'b1; s.dbe = 4'hF; s.daddr = 32'h0C; s.wdata = 32'hFFFFFFFF;
    cyc(s);
    s = '0; s.icen = 1'b1; s.iaddr = 32'h0C; s.dcen = 1'b1; s.daddr = 32'h0C;
    cyc(s);
    @(negedge clk);
    s = '0; s.dcen = 1'b1; s.dwen = 1'b1; s.dbe = 4'hF; s.daddr = 32'h14; s.wdata = 32'h5A5A5A5A;
    drive(s);
    #2;
    nrst = 1'b0;
    #1;
    chk_zero("rst_run");
    drive(stim_t'(0));
    repeat (2) @(posedge clk);
    release_and_clear("rst2");

    for (int w = 0; w < DEPTH; w++) begin
      s = '0; s.icen = 1'b1; s.iaddr = 32'(w) << 2; s.dcen = 1'b1; s.daddr = 32'(DEPTH - 1 - w) << 2;
      cyc(s);
    end
    for (int n = 0; n < 200; n++) cyc(rand_stim());

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
